key_search_scheduler: RTL and testbench
=======================================

KEY_SEARCH_SCHEDULER -- requirements
Module: key_search_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, the number of parallel RC4 crack cores served.
REQ-002 SHALL have parameter KEY_WIDTH, default 24, the secret key width.
REQ-003 SHALL have parameter KEY_LIMIT, default 24'h400000, the first key not searched (exclusive bound).
REQ-004 Clocking and reset SHALL be one clock, with reset asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port go, input, 1 bit: starts a search from key 0 when sampled high in IDLE.
REQ-008 SHALL have port core_start, output, NUM_CORES bits: one-cycle launch pulse per core.
REQ-009 SHALL have port core_key, output, NUM_CORES*KEY_WIDTH bits: per-core key, slice i belongs to core i.
REQ-010 SHALL have port core_done, input, NUM_CORES bits: one-cycle completion pulse per core.
REQ-011 SHALL have port core_found, input, NUM_CORES bits: qualifies core_done; high means the key decrypted validly.
REQ-012 SHALL have port core_abort, output, 1 bit: level that forces all cores idle.
REQ-013 SHALL have port found, output, 1 bit: search succeeded.
REQ-014 SHALL have port exhausted, output, 1 bit: whole key space failed.
REQ-015 SHALL have port found_key, output, KEY_WIDTH bits: the winning key.
REQ-016 SHALL have port keys_tried, output, KEY_WIDTH+1 bits: count of completed key trials.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, FOUND and EXHAUSTED.
REQ-018 IDLE SHALL go to RUN the cycle after go=1, with next_key=0, keys_tried=0 and all busy bits cleared.
REQ-019 In RUN, each cycle SHALL dispatch at most one key to the first non-busy core at or after the round-robin pointer, scanning with wrap.
REQ-020 On dispatch to core i, the block SHALL, in the same registered cycle, pulse core_start[i], load core_key slice i with next_key, set busy[i], increment next_key, and move the pointer to i+1 mod NUM_CORES.
REQ-021 core_key slice i SHALL be stable from the core_start[i] pulse until the next dispatch to core i.
REQ-022 core_done[i] while busy[i]=1 SHALL clear busy[i] and increment keys_tried; core_done[i] while busy[i]=0 SHALL be ignored.
REQ-023 A core that completes in cycle t SHALL be eligible for dispatch in cycle t+1 at the earliest, never in cycle t itself.
REQ-024 When next_key reaches KEY_LIMIT, RUN SHALL move to DRAIN and no further dispatch SHALL occur.
REQ-025 DRAIN SHALL move to EXHAUSTED when all busy bits are 0 and no found result is pending.
REQ-026 core_done[i]&core_found[i] in RUN or DRAIN SHALL move the block to FOUND and capture core_key slice i into found_key.
REQ-027 If several cores report a find in the same cycle, the lowest index SHALL win.
REQ-028 core_abort SHALL be high in FOUND; the block SHALL clear all busy bits on entering FOUND, and no core_start SHALL be issued in FOUND.
REQ-029 found SHALL be high only in FOUND; exhausted SHALL be high only in EXHAUSTED.
REQ-030 FOUND and EXHAUSTED SHALL be terminal until reset.
REQ-031 go SHALL be ignored outside IDLE.
REQ-032 next_key SHALL be KEY_WIDTH+1 bits wide so that the comparison against KEY_LIMIT cannot wrap.

Reset
REQ-033 Reset low SHALL immediately force IDLE, with core_start=0, core_key=0, core_abort=0, found=0, exhausted=0, found_key=0, keys_tried=0, busy=0 and pointer=0.
REQ-034 Reset asserted mid-search SHALL drop all outputs to their reset values; no key is resumed.
REQ-035 All registers SHALL use the same asynchronous active-low reset; there SHALL be no synchronous clear path other than go in IDLE.

Structure
REQ-036 Package key_search_pkg SHALL hold the state enum, KEY_WIDTH and KEY_LIMIT defaults.
REQ-037 Sub-module rr_idle_picker SHALL take NUM_CORES busy bits and the pointer, and return a valid flag plus the selected index.
REQ-038 All outputs SHALL be registered.

Verification
REQ-039 Bench SHALL check: NUM_CORES=4, go, no core ever finds -> core_start order 0,1,2,3 with keys 0,1,2,3, then each done core receives the next key.
REQ-040 Bench SHALL check: core 2 finds on key 6 -> found=1 and found_key=6 next cycle, core_abort=1, no further core_start.
REQ-041 Bench SHALL check: cores 1 and 3 find in the same cycle -> found_key equals core 1's key.
REQ-042 Bench SHALL check: KEY_LIMIT=10, all fail -> exactly 10 core_start pulses, DRAIN until all done, then exhausted=1 with keys_tried=10.
REQ-043 Bench SHALL check: spurious core_done[0] while core 0 is idle -> keys_tried unchanged, no state change.
REQ-044 Bench SHALL check: reset pulsed low during RUN -> all outputs 0 in the same cycle; a fresh go restarts dispatch from key 0.

Source files
------------

// File: rtl/key_search_pkg.sv
// Shared types and parameter defaults for the RC4 key-search scheduler.
package key_search_pkg;

    localparam int               KEY_WIDTH_DEF = 24;
    localparam logic [23:0]      KEY_LIMIT_DEF = 24'h400000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FOUND,
        ST_EXHAUSTED
    } state_e;

endpackage

// File: rtl/rr_idle_picker.sv
// Round-robin picker: first non-busy core at or after the pointer, wrapping.
module rr_idle_picker #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_CORES-1:0] busy_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic                 valid_o,
    output logic [IDX_W-1:0]     idx_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_CORES) begin
                cand = cand - NUM_CORES;
            end
            cand_idx = IDX_W'(cand);
            if (!valid_o && !busy_i[cand_idx]) begin
                valid_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/key_search_scheduler.sv
// Hands out sequential keys to a pool of RC4 crack cores and collects the
// first successful decryption or reports that the key space is exhausted.
//
// state     | meaning
// IDLE      | waiting for go
// RUN       | dispatching keys, collecting results
// DRAIN     | all keys issued, waiting for busy cores to finish
// FOUND     | a core reported a valid key; cores aborted (terminal)
// EXHAUSTED | every key failed (terminal)
module key_search_scheduler
    import key_search_pkg::*;
#(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = KEY_WIDTH_DEF,
    parameter logic [KEY_WIDTH-1:0] KEY_LIMIT = KEY_WIDTH'(KEY_LIMIT_DEF)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           go,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_found,
    output logic                           core_abort,
    output logic                           found,
    output logic                           exhausted,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [KEY_WIDTH:0]             keys_tried
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    state_e                         state_q, state_d;
    logic [KEY_WIDTH:0]             next_key_q, next_key_d;
    logic [KEY_WIDTH:0]             tried_q, tried_d;
    logic [NUM_CORES-1:0]           busy_q, busy_d;
    logic [IDX_W-1:0]               ptr_q, ptr_d;
    logic [NUM_CORES-1:0]           start_q, start_d;
    logic [NUM_CORES*KEY_WIDTH-1:0] key_q, key_d;
    logic [KEY_WIDTH-1:0]           fkey_q, fkey_d;
    logic                           abort_q, found_q, exh_q;

    logic [NUM_CORES-1:0]           done_v, find_v;
    logic [KEY_WIDTH:0]             done_cnt;
    logic [KEY_WIDTH-1:0]           win_key;
    logic                           pick_valid;
    logic [IDX_W-1:0]               pick_idx;
    logic                           limit_reached;

    // Picker sees the registered busy bits, so a core finishing this cycle
    // cannot be re-dispatched before the next one.
    rr_idle_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .busy_i  (busy_q),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign done_v        = core_done & busy_q;
    assign find_v        = done_v & core_found;
    assign limit_reached = (next_key_q >= {1'b0, KEY_LIMIT});

    always_comb begin
        done_cnt = '0;
        win_key  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            done_cnt = done_cnt + (KEY_WIDTH+1)'(done_v[i]);
        end
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (find_v[i]) begin
                win_key = key_q[i*KEY_WIDTH +: KEY_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        next_key_d = next_key_q;
        tried_d    = tried_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        start_d    = '0;
        key_d      = key_q;
        fkey_d     = fkey_q;

        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d    = ST_RUN;
                    next_key_d = '0;
                    tried_d    = '0;
                    busy_d     = '0;
                    ptr_d      = '0;
                end
            end

            ST_RUN, ST_DRAIN: begin
                tried_d = tried_q + done_cnt;
                if (|find_v) begin
                    state_d = ST_FOUND;
                    fkey_d  = win_key;
                    busy_d  = '0;
                end else begin
                    busy_d = busy_q & ~done_v;
                    if (state_q == ST_RUN) begin
                        if (!limit_reached && pick_valid) begin
                            for (int i = 0; i < NUM_CORES; i++) begin
                                if (pick_idx == IDX_W'(i)) begin
                                    start_d[i]                        = 1'b1;
                                    key_d[i*KEY_WIDTH +: KEY_WIDTH]   = next_key_q[KEY_WIDTH-1:0];
                                    busy_d[i]                         = 1'b1;
                                end
                            end
                            next_key_d = next_key_q + 1'b1;
                            ptr_d      = (pick_idx == IDX_W'(NUM_CORES - 1)) ? '0 : pick_idx + 1'b1;
                        end
                        if (next_key_d >= {1'b0, KEY_LIMIT}) begin
                            state_d = ST_DRAIN;
                        end
                    end else if (busy_q == '0) begin
                        state_d = ST_EXHAUSTED;
                    end
                end
            end

            ST_FOUND, ST_EXHAUSTED: begin
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            next_key_q <= '0;
            tried_q    <= '0;
            busy_q     <= '0;
            ptr_q      <= '0;
            start_q    <= '0;
            key_q      <= '0;
            fkey_q     <= '0;
            abort_q    <= 1'b0;
            found_q    <= 1'b0;
            exh_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            next_key_q <= next_key_d;
            tried_q    <= tried_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            start_q    <= start_d;
            key_q      <= key_d;
            fkey_q     <= fkey_d;
            abort_q    <= (state_d == ST_FOUND);
            found_q    <= (state_d == ST_FOUND);
            exh_q      <= (state_d == ST_EXHAUSTED);
        end
    end

    assign core_start = start_q;
    assign core_key   = key_q;
    assign core_abort = abort_q;
    assign found      = found_q;
    assign exhausted  = exh_q;
    assign found_key  = fkey_q;
    assign keys_tried = tried_q;

endmodule

// File: tb/tb_key_search_scheduler.sv
// Scoreboard bench: a key-level reference model predicts dispatches and
// results; a separate monitor pops and compares whenever the DUT reports.
module tb_key_search_scheduler;

    localparam int N   = 4;
    localparam int KW  = 24;
    localparam int LIM = 10;

    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_FOUND = 3, S_EXH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            go = 1'b0;
    logic [N-1:0]    core_start;
    logic [N*KW-1:0] core_key;
    logic [N-1:0]    core_done = '0;
    logic [N-1:0]    core_found = '0;
    logic            core_abort, found, exhausted;
    logic [KW-1:0]   found_key;
    logic [KW:0]     keys_tried;

    key_search_scheduler #(
        .NUM_CORES (N),
        .KEY_WIDTH (KW),
        .KEY_LIMIT (24'd10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .core_start (core_start),
        .core_key   (core_key),
        .core_done  (core_done),
        .core_found (core_found),
        .core_abort (core_abort),
        .found      (found),
        .exhausted  (exhausted),
        .found_key  (found_key),
        .keys_tried (keys_tried)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int cyc; int idx; int key; } start_t;
    typedef struct { int cyc; bit is_found; int key; int tried; } res_t;
    start_t sq[$];
    res_t   rq[$];

    // reference model state
    int  m_state = S_IDLE;
    bit  m_busy[N];
    int  m_key[N];
    int  m_due[N];
    int  m_ptr, m_next, m_tried;

    // scenario knobs
    bit        rand_lat;
    int        fix_lat[N];
    bit [63:0] find_mask;
    bit        spur_en;

    // monitor bookkeeping
    bit prev_term = 0;
    int n_starts = 0;
    int log_idx[$];
    int log_key[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: one sample per cycle, 1ns after the active edge.
    initial begin
        start_t s;
        res_t   r;
        bit     term;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                prev_term = 0;
            end else begin
                while (sq.size() > 0 && sq[0].cyc < cyc) begin
                    s = sq.pop_front();
                    chk("missing_start_cycle", cyc, s.cyc);
                end
                while (rq.size() > 0 && rq[0].cyc < cyc) begin
                    r = rq.pop_front();
                    chk("missing_result_cycle", cyc, r.cyc);
                end
                if (core_start != '0) begin
                    n_starts++;
                    chk("start_onehot", $countones(core_start), 1);
                    if (sq.size() == 0) begin
                        chk("unexpected_start", core_start, 0);
                    end else begin
                        s = sq.pop_front();
                        chk("start_cycle", cyc, s.cyc);
                        chk("start_core", core_start, 1 << s.idx);
                        chk("start_key", core_key[s.idx*KW +: KW], s.key);
                        log_idx.push_back(s.idx);
                        log_key.push_back(int'(core_key[s.idx*KW +: KW]));
                    end
                end
                term = found | exhausted;
                if (term && !prev_term) begin
                    if (rq.size() == 0) begin
                        chk("unexpected_result", {found, exhausted}, 0);
                    end else begin
                        r = rq.pop_front();
                        chk("result_cycle", cyc, r.cyc);
                        chk("result_found", found, r.is_found);
                        chk("result_exhausted", exhausted, !r.is_found);
                        chk("result_abort", core_abort, r.is_found);
                        chk("result_keys_tried", keys_tried, r.tried);
                        if (r.is_found) chk("result_found_key", found_key, r.key);
                    end
                end
                if (prev_term && !term) chk("terminal_dropped", term, 1);
                prev_term = term;
            end
        end
    end

    // One cycle of stimulus plus the model's prediction for the next edge.
    task automatic step(input bit go_now);
        bit [N-1:0] d;
        bit [N-1:0] f;
        bit         busy_before[N];
        int         win, pick, lat;
        bit         all_idle;
        @(negedge clk);
        d = '0;
        f = N'($urandom);
        if (m_state == S_RUN || m_state == S_DRAIN) begin
            for (int i = 0; i < N; i++) begin
                if (m_busy[i] && cyc >= m_due[i]) begin
                    d[i] = 1'b1;
                    f[i] = find_mask[m_key[i]];
                end else if (!m_busy[i] && spur_en && $urandom_range(0, 2) == 0) begin
                    d[i] = 1'b1;
                end
            end
        end else if (m_state != S_IDLE && spur_en) begin
            d = N'($urandom);
        end
        go         = go_now ? 1'b1 : (m_state != S_IDLE && $urandom_range(0, 3) == 0);
        core_done  = d;
        core_found = f;

        case (m_state)
            S_IDLE: begin
                if (go_now) begin
                    m_state = S_RUN;
                    m_next  = 0;
                    m_tried = 0;
                    m_ptr   = 0;
                    for (int i = 0; i < N; i++) m_busy[i] = 0;
                end
            end
            S_RUN, S_DRAIN: begin
                win = -1;
                for (int i = 0; i < N; i++) begin
                    busy_before[i] = m_busy[i];
                    if (d[i] && m_busy[i]) begin
                        m_tried++;
                        if (f[i] && win < 0) win = i;
                    end
                end
                if (win >= 0) begin
                    res_t r;
                    r.cyc = cyc + 1; r.is_found = 1'b1; r.key = m_key[win]; r.tried = m_tried;
                    rq.push_back(r);
                    m_state = S_FOUND;
                    for (int i = 0; i < N; i++) m_busy[i] = 0;
                end else begin
                    for (int i = 0; i < N; i++) if (d[i]) m_busy[i] = 0;
                    if (m_state == S_RUN) begin
                        if (m_next < LIM) begin
                            pick = -1;
                            for (int k = 0; k < N; k++) begin
                                int j;
                                j = (m_ptr + k) % N;
                                if (pick < 0 && !busy_before[j]) pick = j;
                            end
                            if (pick >= 0) begin
                                start_t s;
                                s.cyc = cyc + 1; s.idx = pick; s.key = m_next;
                                sq.push_back(s);
                                lat = rand_lat ? int'($urandom_range(1, 6)) : fix_lat[pick];
                                m_key[pick]  = m_next;
                                m_busy[pick] = 1;
                                m_due[pick]  = cyc + lat;
                                m_next++;
                                m_ptr = (pick + 1) % N;
                            end
                        end
                        if (m_next >= LIM) m_state = S_DRAIN;
                    end else begin
                        all_idle = 1;
                        for (int i = 0; i < N; i++) if (busy_before[i]) all_idle = 0;
                        if (all_idle) begin
                            res_t r;
                            r.cyc = cyc + 1; r.is_found = 1'b0; r.key = 0; r.tried = m_tried;
                            rq.push_back(r);
                            m_state = S_EXH;
                        end
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset     = 1'b0;
        go        = 1'b0;
        core_done = '0;
        #1;
        chk({nm, "_core_start"}, core_start, 0);
        chk({nm, "_core_key_zero"}, core_key == '0, 1);
        chk({nm, "_core_abort"}, core_abort, 0);
        chk({nm, "_found"}, found, 0);
        chk({nm, "_exhausted"}, exhausted, 0);
        chk({nm, "_found_key"}, found_key, 0);
        chk({nm, "_keys_tried"}, keys_tried, 0);
        m_state = S_IDLE;
        m_ptr = 0; m_next = 0; m_tried = 0;
        for (int i = 0; i < N; i++) m_busy[i] = 0;
        sq.delete();
        rq.delete();
        log_idx.delete();
        log_key.delete();
        n_starts  = 0;
        prev_term = 0;
        #2;
        reset = 1'b1;
    endtask

    task automatic run_scen(input string nm);
        int n;
        step(1'b1);
        n = 1;
        while (!(m_state == S_FOUND || m_state == S_EXH) && n < 400) begin
            step(1'b0);
            n++;
        end
        if (n >= 400) begin
            errors++;
            $display("FAIL %s_timeout: no terminal state after %0d cycles, required one", nm, n);
        end
        repeat (6) step(1'b0);
        chk({nm, "_start_queue_left"}, sq.size(), 0);
        chk({nm, "_result_queue_left"}, rq.size(), 0);
    endtask

    function automatic int core_of_key(input int k);
        for (int i = 0; i < log_key.size(); i++) if (log_key[i] == k) return log_idx[i];
        return -1;
    endfunction

    initial begin
        #1;
        chk("rst_core_start", core_start, 0);
        chk("rst_found", found, 0);
        chk("rst_exhausted", exhausted, 0);
        chk("rst_keys_tried", keys_tried, 0);
        #3 reset = 1'b1;

        // all cores fail, equal latency: strict round-robin order
        rand_lat = 0; spur_en = 0; find_mask = '0;
        for (int i = 0; i < N; i++) fix_lat[i] = 5;
        run_scen("rr");
        chk("rr_starts", n_starts, 10);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_order_core%0d", i), log_idx[i], i);
            chk($sformatf("rr_order_key%0d", i), log_key[i], i);
        end
        chk("rr_exhausted", exhausted, 1);
        chk("rr_tried", keys_tried, 10);

        // key 6 lands on core 2 and decrypts
        do_reset("r1");
        find_mask = '0; find_mask[6] = 1'b1;
        run_scen("find6");
        chk("find6_core", core_of_key(6), 2);
        chk("find6_found", found, 1);
        chk("find6_key", found_key, 6);
        chk("find6_abort", core_abort, 1);
        chk("find6_no_start", core_start, 0);

        // cores 1 and 3 report finds in the same cycle
        do_reset("r2");
        find_mask = '0; find_mask[1] = 1'b1; find_mask[3] = 1'b1;
        fix_lat[0] = 30; fix_lat[1] = 5; fix_lat[2] = 30; fix_lat[3] = 3;
        run_scen("tie");
        chk("tie_found_key", found_key, 1);

        // random latency, spurious dones on idle cores, all fail
        do_reset("r3");
        rand_lat = 1; spur_en = 1; find_mask = '0;
        run_scen("exh");
        chk("exh_starts", n_starts, 10);
        chk("exh_exhausted", exhausted, 1);
        chk("exh_tried", keys_tried, 10);

        // reset in the middle of RUN, then a fresh search
        do_reset("r4");
        step(1'b1);
        repeat (6) step(1'b0);
        do_reset("midrun");
        run_scen("restart");
        chk("restart_first_core", log_idx[0], 0);
        chk("restart_first_key", log_key[0], 0);

        for (int t = 0; t < 5; t++) begin
            do_reset($sformatf("rr%0d", t));
            find_mask = '0;
            if ($urandom_range(0, 2) != 0) begin
                find_mask[$urandom_range(0, LIM - 1)] = 1'b1;
                find_mask[$urandom_range(0, LIM - 1)] = 1'b1;
            end
            run_scen($sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
